on_delay_timer: RTL and testbench

Parameterised on-delay (pickup) timer: `hit_target` asserts only after input `in` has been continuously high for `target` clock cycles, and drops as soon as `in` goes low. In the RPSC card logic it qualifies slow permissive chains, e.g. the G2 supply-OK path: `WIDTH=21`, `target=1562500` at a 1.28 µs clock gives ≈2 s. Purely synchronous counting with an asynchronous active-low reset. No handshake.

---
 rtl/on_delay_timer.sv | 70 +++++++
 tb/tb_on_delay_timer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/on_delay_timer.sv
// On-delay (pickup) timer.
// hit_target rises once 'in' has been sampled high on eff consecutive rising
// edges, where eff = max(target, 1), and drops on the first edge that samples
// 'in' low. The counter saturates at eff instead of wrapping, and the live
// target is re-evaluated every cycle, so a lowered target picks up on the next
// edge and a raised one resumes counting from the held value.
module on_delay_timer #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             in,
    output logic             hit_target
);

    // Registered state
    logic [WIDTH-1:0] r_count;
    logic             r_hit;

    // Combinational next-state terms
    logic [WIDTH:0]   w_eff;        // effective target, one bit wider than count
    logic [WIDTH:0]   w_count_inc;  // count + 1 without overflow
    logic             w_below;      // count has not yet reached eff
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_hit_nxt;

    // Effective target and widened increment; a zero target behaves as 1
    always_comb begin
        w_eff       = {{WIDTH{1'b0}}, 1'b1};
        w_count_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
        if (target == {WIDTH{1'b0}}) begin
            w_eff = {{WIDTH{1'b0}}, 1'b1};
        end else begin
            w_eff = {1'b0, target};
        end
        w_below = ({1'b0, r_count} < w_eff);
    end

    // Next count and next output: clear on low input, count up until eff, then hold
    always_comb begin
        w_count_nxt = r_count;
        w_hit_nxt   = 1'b0;
        if (!in) begin
            w_count_nxt = {WIDTH{1'b0}};
            w_hit_nxt   = 1'b0;
        end else if (w_below) begin
            // count + 1 <= eff <= 2^WIDTH-1 here, so the truncation is lossless
            w_count_nxt = w_count_inc[WIDTH-1:0];
            w_hit_nxt   = (w_count_inc >= w_eff);
        end else begin
            w_count_nxt = r_count;
            w_hit_nxt   = 1'b1;
        end
    end

    // State registers, cleared immediately by the active-low asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {WIDTH{1'b0}};
            r_hit   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    assign hit_target = r_hit;

endmodule

// File: tb/tb_on_delay_timer.sv
// Self-checking bench for on_delay_timer.
// A behavioural model of the pickup counter predicts hit_target for every
// driven cycle; the prediction is pushed to a scoreboard queue when the input
// is applied and popped and compared once the clock edge has been taken.
module tb_on_delay_timer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  tgt4;
    logic        in4;
    logic        hit4;
    logic [20:0] tgt21;
    logic        in21;
    logic        hit21;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboards of predicted hit_target values
    logic sb4[$];
    logic sb21[$];

    // Reference model state
    int m4_count  = 0;
    int m21_count = 0;

    on_delay_timer #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .reset      (rst_n),
        .target     (tgt4),
        .in         (in4),
        .hit_target (hit4)
    );

    on_delay_timer #(.WIDTH(21)) dut21 (
        .clk        (clk),
        .reset      (rst_n),
        .target     (tgt21),
        .in         (in21),
        .hit_target (hit21)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the 4-bit DUT: predict, push, take the edge, pop and compare
    task automatic step4(input logic v, input string name);
        int   eff;
        logic exp_hit;
        logic got;
        in4 = v;
        eff = (int'(tgt4) == 0) ? 1 : int'(tgt4);
        if (!v) begin
            m4_count = 0;
            exp_hit  = 1'b0;
        end else if (m4_count < eff) begin
            m4_count = m4_count + 1;
            exp_hit  = (m4_count >= eff);
        end else begin
            exp_hit  = 1'b1;
        end
        sb4.push_back(exp_hit);
        @(posedge clk);
        #1;
        got = sb4.pop_front();
        compared++;
        if (hit4 !== got) begin
            mismatched++;
            $display("FAIL %s: hit_target=%b expected %b (target=%0d count_model=%0d)",
                     name, hit4, got, tgt4, m4_count);
        end
    endtask

    // One clock of the 21-bit DUT with the same model
    task automatic step21(input logic v, input bit check, input string name);
        int   eff;
        logic exp_hit;
        logic got;
        in21 = v;
        eff = (int'(tgt21) == 0) ? 1 : int'(tgt21);
        if (!v) begin
            m21_count = 0;
            exp_hit   = 1'b0;
        end else if (m21_count < eff) begin
            m21_count = m21_count + 1;
            exp_hit   = (m21_count >= eff);
        end else begin
            exp_hit   = 1'b1;
        end
        sb21.push_back(exp_hit);
        @(posedge clk);
        #1;
        got = sb21.pop_front();
        if (check) begin
            compared++;
            if (hit21 !== got) begin
                mismatched++;
                $display("FAIL %s: hit_target=%b expected %b at edge %0d",
                         name, hit21, got, m21_count);
            end
        end
    endtask

    task automatic check_count4(input int exp_c, input string name);
        compared++;
        if (int'(dut4.r_count) !== exp_c) begin
            mismatched++;
            $display("FAIL %s: count=%0d expected %0d", name, dut4.r_count, exp_c);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m4_count  = 0;
        m21_count = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tgt4  = 4'd8;
        in4   = 1'b0;
        tgt21 = 21'd0;
        in21  = 1'b0;
        #2;
        compared++;
        if (hit4 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hit: hit_target=%b expected 0", hit4);
        end
        check_count4(0, "reset_count");
        release_reset();
    endtask

    task automatic test_pickup();
        tgt4 = 4'd8;
        for (int i = 0; i < 8; i++) step4(1'b1, "pickup");
        for (int i = 0; i < 20; i++) step4(1'b1, "pickup_hold");
        check_count4(8, "pickup_saturate");
    endtask

    task automatic test_drop();
        step4(1'b0, "drop");
        for (int i = 0; i < 8; i++) step4(1'b1, "drop_repickup");
    endtask

    task automatic test_glitch();
        step4(1'b0, "glitch_pre");
        for (int i = 0; i < 5; i++) step4(1'b1, "glitch_first");
        step4(1'b0, "glitch_low");
        for (int i = 0; i < 10; i++) step4(1'b1, "glitch_restart");
    endtask

    task automatic test_target_edges();
        step4(1'b0, "t0_pre");
        tgt4 = 4'd0;
        for (int i = 0; i < 3; i++) step4(1'b1, "target_zero");
        step4(1'b0, "t1_pre");
        tgt4 = 4'd1;
        for (int i = 0; i < 3; i++) step4(1'b1, "target_one");
        step4(1'b0, "t15_pre");
        tgt4 = 4'd15;
        for (int i = 0; i < 15; i++) step4(1'b1, "target_max");
        for (int i = 0; i < 30; i++) step4(1'b1, "target_max_hold");
        check_count4(15, "target_max_nowrap");
    endtask

    task automatic test_live_target();
        tgt4 = 4'd8;
        step4(1'b0, "live_pre");
        for (int i = 0; i < 5; i++) step4(1'b1, "live_count");
        tgt4 = 4'd3;
        step4(1'b1, "live_lower");
        step4(1'b1, "live_lower_hold");
        tgt4 = 4'd12;
        for (int i = 0; i < 8; i++) step4(1'b1, "live_raise");
        tgt4 = 4'd8;
    endtask

    task automatic test_async_reset();
        tgt4 = 4'd8;
        step4(1'b0, "areset_pre");
        for (int i = 0; i < 5; i++) step4(1'b1, "areset_count");
        check_count4(5, "areset_count5");
        #2;
        rst_n = 1'b0;
        #1;
        check_count4(0, "areset_midcount_clear");
        release_reset();
        for (int i = 0; i < 8; i++) step4(1'b1, "areset_recount");
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (hit4 !== 1'b0) begin
            mismatched++;
            $display("FAIL areset_hit_clear: hit_target=%b expected 0", hit4);
        end
        release_reset();
        for (int i = 0; i < 9; i++) step4(1'b1, "areset_repickup");
    endtask

    task automatic test_wide();
        tgt21 = 21'd40000;
        step21(1'b0, 1'b1, "wide_pre");
        for (int i = 1; i <= 40003; i++) begin
            step21(1'b1, (i >= 39998), "wide_pickup");
        end
        step21(1'b0, 1'b1, "wide_drop");
    endtask

    initial begin
        test_reset();
        test_pickup();
        test_drop();
        test_glitch();
        test_target_edges();
        test_live_target();
        test_async_reset();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
